// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc: RPN calculator operand stack driven by synchronized active-low pushbuttons.
module rpn_stack_calc #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [3:0]       key,
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] next,
    output logic [7:0]       counter,
    output logic             err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DMAX = 8'(DEPTH);

    logic [3:0]       s1_q, s2_q, s3_q;
    logic             v1_q, v2_q;
    logic [3:0]       press;
    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [WIDTH-1:0] top_q, top_d, next_q, next_d, third, res;
    logic [7:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             we0, we1;
    logic [AW-1:0]    ci, wa0, wa1;
    logic [WIDTH-1:0] wd0, wd1;

    assign top     = top_q;
    assign next    = next_q;
    assign counter = cnt_q;
    assign err     = err_q;

    // s3 only ever holds real key samples, so a key held across reset release never looks like a fresh fall
    assign press = s3_q & ~s2_q;
    assign ci    = cnt_q[AW-1:0];
    assign third = (cnt_q >= 8'd3) ? stk_q[ci - AW'(3)] : '0;

    // two-flop synchronizer, history flop, and a fill tracker that marks s2 as holding a real sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 4'hF;
            s2_q <= 4'hF;
            s3_q <= 4'h0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            s1_q <= key;
            s2_q <= s1_q;
            s3_q <= v2_q ? s2_q : 4'h0;
            v1_q <= 1'b1;
            v2_q <= v1_q;
        end
    end

    // ALU result for key2/key3 binary ops; key2 wins when both are pressed
    always_comb begin
        res = '0;
        unique case (mode)
            2'b00:   res = press[2] ? next_q + top_q : next_q - top_q;
            2'b01:   res = press[2] ? next_q & top_q : next_q | top_q;
            2'b10:   res = press[2] ? next_q << top_q[3:0] : next_q >> top_q[3:0];
            default: res = '0;
        endcase
    end

    // commit logic: one action per detected press, lowest key index has priority
    always_comb begin
        top_d  = top_q;
        next_d = next_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        we0    = 1'b0;
        we1    = 1'b0;
        wa0    = ci;
        wa1    = ci - AW'(2);
        wd0    = val;
        wd1    = top_q;
        if (press[0]) begin
            if (cnt_q < DMAX) begin
                we0    = 1'b1;
                top_d  = val;
                next_d = top_q;
                cnt_d  = cnt_q + 8'd1;
                err_d  = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (press[1]) begin
            if (cnt_q != 8'd0) begin
                top_d  = next_q;
                next_d = third;
                cnt_d  = cnt_q - 8'd1;
                err_d  = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (press[3] && mode == 2'b11 && !press[2]) begin
            if (cnt_q != 8'd0 && cnt_q < DMAX) begin
                we0    = 1'b1;
                wd0    = top_q;
                next_d = top_q;
                cnt_d  = cnt_q + 8'd1;
                err_d  = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (press[2] || press[3]) begin
            if (cnt_q < 8'd2) begin
                err_d = 1'b1;
            end else if (mode == 2'b11) begin
                we0    = 1'b1;
                we1    = 1'b1;
                wa0    = ci - AW'(1);
                wd0    = next_q;
                top_d  = next_q;
                next_d = top_q;
                err_d  = 1'b0;
            end else begin
                we0    = 1'b1;
                wa0    = ci - AW'(2);
                wd0    = res;
                top_d  = res;
                next_d = third;
                cnt_d  = cnt_q - 8'd1;
                err_d  = 1'b0;
            end
        end
    end

    // stack storage; entries above the depth are don't-care so no reset is needed
    always_ff @(posedge clk) begin
        if (we0) stk_q[wa0] <= wd0;
        if (we1) stk_q[wa1] <= wd1;
    end

    // registered display views, depth and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_q  <= '0;
            next_q <= '0;
            cnt_q  <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            top_q  <= top_d;
            next_q <= next_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end
endmodule
